// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone definitions: cycle/burst type codes, memory-slave FSM states
// and the burst next-address helper.
package peripheral_wb_pkg;

  localparam logic [2:0] CLASSIC     = 3'b000;
  localparam logic [2:0] CONST_BURST = 3'b001;
  localparam logic [2:0] INC_BURST   = 3'b010;
  localparam logic [2:0] END_BURST   = 3'b111;

  localparam logic [1:0] LINEAR = 2'b00;
  localparam logic [1:0] WRAP4  = 2'b01;
  localparam logic [1:0] WRAP8  = 2'b10;
  localparam logic [1:0] WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2
  } wb_mem_state_t;

  // Wrap bursts keep the bits above the window and advance only inside it.
  function automatic logic [63:0] wb_next_adr(input logic [63:0] adr,
                                               input logic [2:0]  cti,
                                               input logic [1:0]  bte,
                                               input int          dw);
    logic [63:0] inc;
    logic [63:0] sum;
    logic [63:0] mask;
    inc = 64'(dw / 8);
    sum = adr + inc;
    case (bte)
      WRAP4:   mask = (inc << 2) - 64'd1;
      WRAP8:   mask = (inc << 3) - 64'd1;
      WRAP16:  mask = (inc << 4) - 64'd1;
      default: mask = '1;
    endcase
    if (cti == CONST_BURST) return adr;
    return (adr & ~mask) | (sum & mask);
  endfunction

endpackage

// File: rtl/peripheral_memory_wb_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port.
module peripheral_memory_wb_ram #(
  parameter int    DW          = 32,
  parameter int    DEPTH       = 8192,
  parameter int    IW          = 13,
  parameter string MEMORY_FILE = ""
) (
  input  logic            clk,
  input  logic [IW-1:0]   addr,
  input  logic [DW/8-1:0] wr_be,
  input  logic [DW-1:0]   wr_data,
  output logic [DW-1:0]   rd_data
);

  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++) begin
      if (wr_be[b]) mem[addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
    rd_data <= mem[addr];
  end

endmodule

// File: rtl/peripheral_memory_wb.sv
// Wishbone B3 memory slave: classic and registered-feedback bursts, byte
// selects, first-beat wait states, out-of-range error and beat counters.
//
// state | meaning
// IDLE  | no cycle; on req latch address/bte/we and start the first RAM read
// WAIT  | first-beat wait states counting down
// BEAT  | ack/err asserted while req; bursts stay here, one beat per cycle
module peripheral_memory_wb
  import peripheral_wb_pkg::*;
#(
  parameter int          DW             = 32,
  parameter int          AW             = 32,
  parameter logic [31:0] MEM_SIZE_BYTES = 32'h0000_8000,
  parameter int          WAIT_STATES    = 0,
  parameter string       MEMORY_FILE    = "",
  parameter int          CNT_W          = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [AW-1:0]    wb_adr_i,
  input  logic [DW-1:0]    wb_dat_i,
  input  logic [DW/8-1:0]  wb_sel_i,
  input  logic             wb_we_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  output logic [DW-1:0]    wb_dat_o,
  output logic [CNT_W-1:0] read_count_o,
  output logic [CNT_W-1:0] write_count_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int BPW     = DW / 8;
  localparam int ADR_LSB = $clog2(BPW);
  localparam int DEPTH   = int'(MEM_SIZE_BYTES) / BPW;
  localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW      = AW - ADR_LSB;

  wb_mem_state_t state;
  logic [AW-1:0] adr_q;
  logic [1:0]    bte_q;
  logic          we_q;
  logic [3:0]    ws_cnt;

  logic          req;
  logic          beat;
  logic          oor;
  logic          burst_cont;
  logic [AW-1:0] adr_nxt;
  logic [IW-1:0] ram_idx;
  logic [BPW-1:0] ram_be;
  logic [DW-1:0] ram_rdata;

  assign req        = wb_cyc_i & wb_stb_i;
  assign oor        = (adr_q[AW-1:ADR_LSB] >= XW'(DEPTH));
  assign beat       = (state == BEAT) & req;
  assign wb_ack_o   = beat & ~oor;
  assign wb_err_o   = beat & oor;
  assign wb_rty_o   = 1'b0;
  assign wb_dat_o   = (wb_ack_o && !we_q) ? ram_rdata : '0;
  assign burst_cont = (wb_cti_i == CONST_BURST) || (wb_cti_i == INC_BURST);
  assign adr_nxt    = AW'(wb_next_adr(64'(adr_q), wb_cti_i, bte_q, DW));
  assign ram_be     = (wb_ack_o && we_q) ? wb_sel_i : '0;

  // Read-ahead: the next burst word is fetched on the edge that acks the
  // current one so following beats need no extra cycle.
  always_comb begin
    ram_idx = adr_q[ADR_LSB +: IW];
    if (state == IDLE) begin
      ram_idx = wb_adr_i[ADR_LSB +: IW];
    end else if (wb_ack_o && !we_q && burst_cont) begin
      ram_idx = adr_nxt[ADR_LSB +: IW];
    end
  end

  peripheral_memory_wb_ram #(
    .DW          (DW),
    .DEPTH       (DEPTH),
    .IW          (IW),
    .MEMORY_FILE (MEMORY_FILE)
  ) u_ram (
    .clk     (wb_clk_i),
    .addr    (ram_idx),
    .wr_be   (ram_be),
    .wr_data (wb_dat_i),
    .rd_data (ram_rdata)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      adr_q         <= '0;
      bte_q         <= LINEAR;
      we_q          <= 1'b0;
      ws_cnt        <= '0;
      read_count_o  <= '0;
      write_count_o <= '0;
      err_count_o   <= '0;
    end else begin
      if (wb_ack_o && we_q)  write_count_o <= write_count_o + CNT_W'(1);
      if (wb_ack_o && !we_q) read_count_o  <= read_count_o + CNT_W'(1);
      if (wb_err_o)          err_count_o   <= err_count_o + CNT_W'(1);

      case (state)
        IDLE: begin
          if (req) begin
            adr_q <= wb_adr_i;
            bte_q <= wb_bte_i;
            we_q  <= wb_we_i;
            if (WAIT_STATES == 0) begin
              state <= BEAT;
            end else begin
              state  <= WAIT;
              ws_cnt <= 4'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (!wb_cyc_i)         state  <= IDLE;
          else if (ws_cnt <= 4'd1) state <= BEAT;
          else                   ws_cnt <= ws_cnt - 4'd1;
        end
        BEAT: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (wb_stb_i) begin
            if (oor || !burst_cont) state <= IDLE;
            else                    adr_q <= adr_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_memory_wb.sv
// Scoreboard bench for peripheral_memory_wb: one zero-wait-state slave and one
// three-wait-state slave share the bus signals but have separate cyc/stb.
module tb_peripheral_memory_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic        we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        cyc0, stb0, cyc1, stb1;
  logic        ack0, err0, rty0, ack1, err1, rty1;
  logic [31:0] dat0, dat1, rc0, wc0, ec0, rc1, wc1, ec1;

  always #5 clk = ~clk;

  peripheral_memory_wb #(.DW(32), .AW(32), .MEM_SIZE_BYTES(32'd256), .WAIT_STATES(0),
                         .MEMORY_FILE(""), .CNT_W(32)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cti_i(cti), .wb_bte_i(bte), .wb_cyc_i(cyc0), .wb_stb_i(stb0),
    .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0), .wb_dat_o(dat0),
    .read_count_o(rc0), .write_count_o(wc0), .err_count_o(ec0));

  peripheral_memory_wb #(.DW(32), .AW(32), .MEM_SIZE_BYTES(32'd256), .WAIT_STATES(3),
                         .MEMORY_FILE(""), .CNT_W(32)) u_dut_ws (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cti_i(cti), .wb_bte_i(bte), .wb_cyc_i(cyc1), .wb_stb_i(stb1),
    .wb_ack_o(ack1), .wb_err_o(err1), .wb_rty_o(rty1), .wb_dat_o(dat1),
    .read_count_o(rc1), .write_count_o(wc1), .err_count_o(ec1));

  typedef struct packed {
    logic        err;
    logic        we;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] bd[8];
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_rd = 0, exp_wr = 0, exp_errc = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] tb_adr(input logic [31:0] a0, input int i,
                                         input logic [2:0] c, input logic [1:0] b);
    logic [31:0] win;
    logic [31:0] base;
    if (c == 3'b001) return a0;
    case (b)
      2'b01:   win = 32'd16;
      2'b10:   win = 32'd32;
      2'b11:   win = 32'd64;
      default: return a0 + 32'(4 * i);
    endcase
    base = a0 - (a0 % win);
    return base + ((a0 - base + 32'(4 * i)) % win);
  endfunction

  // Monitor: pops one expectation per ack/err beat on either slave.
  always @(negedge clk) begin
    if (!rst) begin
      if (!ack0) check("dat0_zero_without_ack", dat0, 32'd0);
      if (!ack1) check("dat1_zero_without_ack", dat1, 32'd0);
      if (ack0 || err0) check("resp0_needs_cyc", 32'(cyc0), 32'd1);
      if (ack0 || err0 || ack1 || err1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("err_flag", 32'(err0 | err1), 32'(e.err));
          check("ack_flag", 32'(ack0 | ack1), 32'(!e.err));
          if (!e.err && !e.we) check("rd_data", dat0 | dat1, e.dat);
        end
      end
    end
  end

  task automatic burst(input bit dsel, input logic [31:0] a0, input bit w,
                       input logic [2:0] ctib, input logic [1:0] bt, input int n,
                       input logic [3:0] sl, input bit exp_err, input int stop_after,
                       input bit do_rst);
    int   t;
    int   ws;
    bit   resp;
    exp_t e;
    ws = dsel ? 3 : 0;
    if (dsel) begin cyc1 = 1'b1; stb1 = 1'b1; end
    else      begin cyc0 = 1'b1; stb0 = 1'b1; end
    for (int i = 0; i < n; i++) begin
      adr   = tb_adr(a0, i, ctib, bt);
      dat_w = w ? bd[i] : $urandom;
      we    = w;
      sel   = sl;
      bte   = bt;
      cti   = (n == 1) ? ctib : ((i == n - 1) ? 3'b111 : ctib);
      e.err = exp_err;
      e.we  = w;
      e.dat = bd[i];
      sb_q.push_back(e);
      if (!dsel) begin
        if (exp_err) exp_errc++;
        else if (w)  exp_wr++;
        else         exp_rd++;
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
        resp = dsel ? (ack1 | err1) : (ack0 | err0);
      end while (!resp && t < 20);
      check("beat_timeout", 32'(resp), 32'd1);
      check("beat_latency", 32'(t), 32'((i == 0) ? 2 + ws : 1));
      @(posedge clk);
      #1;
      if (i + 1 == stop_after) begin
        if (do_rst) begin
          rst = 1'b1;
          #1;
          check("rst_ack", 32'(ack0), 32'd0);
          check("rst_wr_cnt", wc0, 32'd0);
          check("rst_rd_cnt", rc0, 32'd0);
          check("rst_err_cnt", ec0, 32'd0);
          cyc0 = 1'b0; stb0 = 1'b0;
          sb_q.delete();
          exp_rd = 0; exp_wr = 0; exp_errc = 0;
          @(negedge clk);
          rst = 1'b0;
          @(posedge clk);
          #1;
        end
        break;
      end
    end
    cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_wr_cnt"},  wc0, 32'(exp_wr));
    check({tag, "_rd_cnt"},  rc0, 32'(exp_rd));
    check({tag, "_err_cnt"}, ec0, 32'(exp_errc));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1;
    adr = '0; dat_w = '0; sel = '0; we = 1'b0; cti = '0; bte = '0;
    cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    check("reset_ack", 32'(ack0), 32'd0);
    check("reset_err", 32'(err0), 32'd0);
    check("reset_rty", 32'(rty0), 32'd0);
    check_counts("reset");

    // classic write then read
    bd[0] = 32'hDEADBEEF;
    burst(0, 32'h10, 1, 3'b000, 2'b00, 1, 4'hF, 0, 0, 0);
    burst(0, 32'h10, 0, 3'b000, 2'b00, 1, 4'hF, 0, 0, 0);
    check("classic_wr_cnt", wc0, 32'd1);
    check("classic_rd_cnt", rc0, 32'd1);

    // incrementing burst write/read at 0x20
    bd[0] = 32'h11111111; bd[1] = 32'h22222222; bd[2] = 32'h33333333; bd[3] = 32'h44444444;
    burst(0, 32'h20, 1, 3'b010, 2'b00, 4, 4'hF, 0, 0, 0);
    burst(0, 32'h20, 0, 3'b010, 2'b00, 4, 4'hF, 0, 0, 0);

    // wrap-4 read from 0x0C
    bd[0] = 32'hA0A0A0A0; bd[1] = 32'hB1B1B1B1; bd[2] = 32'hC2C2C2C2; bd[3] = 32'hD3D3D3D3;
    burst(0, 32'h00, 1, 3'b010, 2'b00, 4, 4'hF, 0, 0, 0);
    bd[0] = 32'hD3D3D3D3; bd[1] = 32'hA0A0A0A0; bd[2] = 32'hB1B1B1B1; bd[3] = 32'hC2C2C2C2;
    burst(0, 32'h0C, 0, 3'b010, 2'b01, 4, 4'hF, 0, 0, 0);

    // byte selects
    bd[0] = 32'hFFFFFFFF;
    burst(0, 32'h30, 1, 3'b000, 2'b00, 1, 4'hF, 0, 0, 0);
    bd[0] = 32'h11223344;
    burst(0, 32'h30, 1, 3'b000, 2'b00, 1, 4'b0101, 0, 0, 0);
    bd[0] = 32'hFF22FF44;
    burst(0, 32'h30, 0, 3'b000, 2'b00, 1, 4'hF, 0, 0, 0);

    // constant-address burst
    bd[0] = 32'hFF22FF44; bd[1] = 32'hFF22FF44; bd[2] = 32'hFF22FF44;
    burst(0, 32'h30, 0, 3'b001, 2'b00, 3, 4'hF, 0, 0, 0);

    // unsupported cti acts as classic; next request must restart from IDLE
    bd[0] = 32'hDEADBEEF;
    burst(0, 32'h10, 0, 3'b011, 2'b00, 1, 4'hF, 0, 0, 0);
    bd[0] = 32'h11111111;
    burst(0, 32'h20, 0, 3'b000, 2'b00, 1, 4'hF, 0, 0, 0);
    check_counts("mid");

    // out of range: word 64 aliases RAM word 0, which must stay intact
    bd[0] = 32'h0;
    burst(0, 32'h100, 0, 3'b000, 2'b00, 1, 4'hF, 1, 0, 0);
    bd[0] = 32'hBAD0BAD0;
    burst(0, 32'h100, 1, 3'b000, 2'b00, 1, 4'hF, 1, 0, 0);
    bd[0] = 32'hA0A0A0A0;
    burst(0, 32'h00, 0, 3'b000, 2'b00, 1, 4'hF, 0, 0, 0);
    check("oor_err_cnt", ec0, 32'd2);
    check_counts("oor");

    // abort 8-beat burst after beat 2
    bd[0] = 32'h11111111; bd[1] = 32'h22222222; bd[2] = 32'h33333333; bd[3] = 32'h44444444;
    bd[4] = 32'h0; bd[5] = 32'h0; bd[6] = 32'h0; bd[7] = 32'h0;
    burst(0, 32'h20, 0, 3'b010, 2'b00, 8, 4'hF, 0, 2, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack0 || err0) seen = 1'b1;
    end
    check("ack_after_abort", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    bd[0] = 32'hDEADBEEF;
    burst(0, 32'h10, 0, 3'b000, 2'b00, 1, 4'hF, 0, 0, 0);
    check_counts("abort");

    // wait-state slave
    bd[0] = 32'h0BADF00D;
    burst(1, 32'h40, 1, 3'b000, 2'b00, 1, 4'hF, 0, 0, 0);
    burst(1, 32'h40, 0, 3'b000, 2'b00, 1, 4'hF, 0, 0, 0);
    @(negedge clk);
    check("ws_ack_single", 32'(ack1), 32'd0);
    check("ws_dat_after", dat1, 32'd0);
    @(posedge clk);
    #1;
    check("ws_wr_cnt", wc1, 32'd1);
    check("ws_rd_cnt", rc1, 32'd1);

    // reset in the middle of a write burst
    bd[0] = 32'h5555AAAA;
    burst(0, 32'h84, 1, 3'b000, 2'b00, 1, 4'hF, 0, 0, 0);
    bd[0] = 32'hC0DE0001; bd[1] = 32'hC0DE0002; bd[2] = 32'hC0DE0003; bd[3] = 32'hC0DE0004;
    burst(0, 32'h80, 1, 3'b010, 2'b00, 4, 4'hF, 0, 1, 1);
    bd[0] = 32'hC0DE0001;
    burst(0, 32'h80, 0, 3'b000, 2'b00, 1, 4'hF, 0, 0, 0);
    bd[0] = 32'h5555AAAA;
    burst(0, 32'h84, 0, 3'b000, 2'b00, 1, 4'hF, 0, 0, 0);
    check("post_rst_rd_cnt", rc0, 32'd2);
    check_counts("post_rst");

    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
